// File: rtl/bnn_stream_feeder.sv
// Streams feature words into a packed vector for a binarized classifier, pulses its
// reset, waits out its latency, then hands back the prediction and keeps a score.
module bnn_stream_feeder #(
   parameter int FEAT_CNT    = 11,
   parameter int FEAT_BITS   = 4,
   parameter int CLASS_CNT   = 6,
   parameter int BNN_LATENCY = 47,
   parameter int TEST_CNT    = 1000
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [FEAT_BITS-1:0]              in_feat,
   input  logic [$clog2(CLASS_CNT)-1:0]      in_label,
   output logic [FEAT_CNT*FEAT_BITS-1:0]     features,
   output logic                              bnn_rst,
   input  logic [$clog2(CLASS_CNT)-1:0]      bnn_pred,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [$clog2(CLASS_CNT)-1:0]      out_pred,
   output logic                              out_correct,
   output logic [$clog2(TEST_CNT+1)-1:0]     correct_cnt,
   output logic                              done
);

   localparam int LBL_W  = $clog2(CLASS_CNT);
   localparam int CNT_W  = $clog2(TEST_CNT+1);
   localparam int K_W    = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;
   localparam int WAIT_W = (BNN_LATENCY > 1) ? $clog2(BNN_LATENCY) : 1;

   localparam logic [2:0] S_LOAD   = 3'd0;
   localparam logic [2:0] S_SETTLE = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_OUT    = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   logic [2:0]        state;
   logic [K_W-1:0]    k;
   logic [WAIT_W-1:0] wait_cnt;
   logic [CNT_W-1:0]  sample_cnt;
   logic [CNT_W-1:0]  sample_nxt;
   logic [LBL_W-1:0]  label;

   // Handshakes: a word moves when in_valid && in_ready at a rising edge; a result
   // moves when out_valid && out_ready. Both ready/valid outputs are forced low in reset.
   assign in_ready   = !rst && (state == S_LOAD);
   assign out_valid  = !rst && (state == S_OUT);
   assign done       = !rst && (state == S_DONE);
   assign bnn_rst    = rst || (state == S_SETTLE);
   assign sample_nxt = sample_cnt + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_LOAD;
         k           <= '0;
         wait_cnt    <= '0;
         sample_cnt  <= '0;
         correct_cnt <= '0;
         features    <= '0;
         label       <= '0;
         out_pred    <= '0;
         out_correct <= 1'b0;
      end else begin
         case (state)
            S_LOAD: begin
               if (in_valid) begin
                  for (int i = 0; i < FEAT_CNT; i++) begin
                     if (k == K_W'(i)) features[i*FEAT_BITS +: FEAT_BITS] <= in_feat;
                  end
                  if (k == K_W'(FEAT_CNT-1)) begin
                     label <= in_label;
                     k     <= '0;
                     state <= S_SETTLE;
                  end else begin
                     k <= k + K_W'(1);
                  end
               end
            end
            S_SETTLE: begin
               wait_cnt <= '0;
               state    <= S_WAIT;
            end
            S_WAIT: begin
               // The capture cycle does not advance the counter so it never wraps.
               if (wait_cnt == WAIT_W'(BNN_LATENCY-1)) begin
                  out_pred    <= bnn_pred;
                  out_correct <= (bnn_pred == label);
                  state       <= S_OUT;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            S_OUT: begin
               if (out_ready) begin
                  if (out_correct) correct_cnt <= correct_cnt + CNT_W'(1);
                  sample_cnt <= sample_nxt;
                  state      <= (sample_nxt == CNT_W'(TEST_CNT)) ? S_DONE : S_LOAD;
               end
            end
            S_DONE: state <= S_DONE;
            default: state <= S_LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_bnn_stream_feeder.sv
// Bench for bnn_stream_feeder: vector table, reset corner cases and a full randomized
// run, all compared against a word-array reference model.
module tb_bnn_stream_feeder;

   localparam int FEAT_CNT    = 11;
   localparam int FEAT_BITS   = 4;
   localparam int CLASS_CNT   = 6;
   localparam int BNN_LATENCY = 47;
   localparam int TEST_CNT    = 1000;
   localparam int LBL_W       = $clog2(CLASS_CNT);
   localparam int CNT_W       = $clog2(TEST_CNT+1);
   localparam int FV_W        = FEAT_CNT*FEAT_BITS;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [FEAT_BITS-1:0] in_feat;
   logic [LBL_W-1:0] in_label;
   logic [FV_W-1:0]  features;
   logic             bnn_rst;
   logic [LBL_W-1:0] bnn_pred;
   logic             out_valid;
   logic             out_ready;
   logic [LBL_W-1:0] out_pred;
   logic             out_correct;
   logic [CNT_W-1:0] correct_cnt;
   logic             done;

   bnn_stream_feeder #(
      .FEAT_CNT(FEAT_CNT), .FEAT_BITS(FEAT_BITS), .CLASS_CNT(CLASS_CNT),
      .BNN_LATENCY(BNN_LATENCY), .TEST_CNT(TEST_CNT)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_feat(in_feat), .in_label(in_label), .features(features),
      .bnn_rst(bnn_rst), .bnn_pred(bnn_pred), .out_valid(out_valid),
      .out_ready(out_ready), .out_pred(out_pred), .out_correct(out_correct),
      .correct_cnt(correct_cnt), .done(done)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp;
   int n_bad;

   // reference model: one slot per feature plus score counters
   logic [FEAT_BITS-1:0] m_words [FEAT_CNT];
   int m_correct;
   int m_samples;

   typedef struct {
      logic [FV_W-1:0]  fv;
      logic [LBL_W-1:0] lbl;
      logic [LBL_W-1:0] pred;
      int               hold;
      int               pct;
      logic             exp_correct;
   } vec_t;

   vec_t vecs [6];

   function automatic logic [FV_W-1:0] m_features();
      logic [FV_W-1:0] v;
      v = '0;
      for (int i = 0; i < FEAT_CNT; i++) v[i*FEAT_BITS +: FEAT_BITS] = m_words[i];
      return v;
   endfunction

   function automatic logic [LBL_W-1:0] junk(input logic [LBL_W-1:0] avoid);
      logic [LBL_W-1:0] v;
      v = LBL_W'($urandom);
      if (v == avoid) v = avoid + LBL_W'(1);
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_feat = FEAT_BITS'($urandom); in_label = LBL_W'($urandom);
      tick();
      check("rst_features", features, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_done", done, 0);
      check("rst_bnn_rst", bnn_rst, 1);
      check("rst_correct_cnt", correct_cnt, 0);
      check("rst_out_pred", out_pred, 0);
      check("rst_out_correct", out_correct, 0);
      tick();
      rst = 1'b0;
      #1;
      check("in_ready_after_rst", in_ready, 1);
      for (int i = 0; i < FEAT_CNT; i++) m_words[i] = '0;
      m_correct = 0;
      m_samples = 0;
   endtask

   // driver: offer one word, stalling in_valid randomly, until it is accepted
   task automatic send_word(input logic [FEAT_BITS-1:0] w, input int idx,
                            input logic [LBL_W-1:0] lbl, input int pct);
      bit ok;
      int guard;
      ok = 1'b0;
      guard = 0;
      while (!ok && guard < 500) begin
         guard++;
         if (int'($urandom_range(0, 99)) < pct) begin
            in_valid = 1'b1;
            in_feat  = w;
            in_label = (idx == FEAT_CNT-1) ? lbl : LBL_W'($urandom);
         end else begin
            in_valid = 1'b0;
            in_feat  = FEAT_BITS'($urandom);
            in_label = LBL_W'($urandom);
         end
         if (in_valid && in_ready) ok = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: word %0d not accepted within 500 cycles", idx);
      end else begin
         m_words[idx] = w;
         check("features_pack", features, m_features());
      end
   endtask

   task automatic run_sample(input logic [FV_W-1:0] fv, input logic [LBL_W-1:0] lbl,
                             input logic [LBL_W-1:0] pred, input int hold, input int pct,
                             output logic got_correct);
      int t;
      int rst_hi;
      int ready_leak;
      logic exp_c;
      exp_c = (pred == lbl);
      for (int i = 0; i < FEAT_CNT; i++) send_word(fv[i*FEAT_BITS +: FEAT_BITS], i, lbl, pct);
      check("settle_bnn_rst", bnn_rst, 1);
      check("settle_in_ready", in_ready, 0);
      t = 0;
      rst_hi = 0;
      ready_leak = 0;
      // the prediction is only correct on the single cycle the feeder should capture it
      while (!out_valid && t < 200) begin
         bnn_pred = (t == BNN_LATENCY) ? pred : junk(pred);
         in_valid = 1'($urandom);
         in_feat  = FEAT_BITS'($urandom);
         tick();
         t++;
         if (bnn_rst) rst_hi++;
         if (in_ready) ready_leak++;
      end
      in_valid = 1'b0;
      check("latency", t, BNN_LATENCY+1);
      check("bnn_rst_one_cycle", rst_hi, 0);
      check("wait_in_ready", ready_leak, 0);
      check("features_hold", features, m_features());
      check("out_pred", out_pred, pred);
      check("out_correct", out_correct, exp_c);
      got_correct = out_correct;
      for (int h = 0; h < hold; h++) begin
         out_ready = 1'b0;
         bnn_pred  = LBL_W'($urandom);
         in_valid  = 1'($urandom);
         tick();
         check("hold_out_pred", out_pred, pred);
         check("hold_out_valid", out_valid, 1);
         check("hold_in_ready", in_ready, 0);
         check("hold_correct_cnt", correct_cnt, m_correct);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      m_samples++;
      if (exp_c) m_correct++;
      check("correct_cnt", correct_cnt, m_correct);
      check("done", done, (m_samples == TEST_CNT));
      check("out_valid_drop", out_valid, 0);
      check("in_ready_after_xfer", in_ready, (m_samples != TEST_CNT));
      check("features_after_xfer", features, m_features());
   endtask

   initial begin
      logic got;
      logic [FV_W-1:0] rfv;
      logic [LBL_W-1:0] rl;
      n_cmp = 0; n_bad = 0;
      rst = 1'b1; in_valid = 1'b0; in_feat = '0; in_label = '0;
      bnn_pred = '0; out_ready = 1'b0;

      vecs[0] = '{44'hBA987654321, 3'd2, 3'd2, 0,  100, 1'b1};
      vecs[1] = '{44'hFFFFFFFFFFF, 3'd5, 3'd5, 20, 100, 1'b1};
      vecs[2] = '{44'h0123456789A, 3'd0, 3'd7, 3,  50,  1'b0};
      vecs[3] = '{44'h5A5A5A5A5A5, 3'd3, 3'd2, 1,  60,  1'b0};
      vecs[4] = '{44'h00000000000, 3'd1, 3'd1, 0,  80,  1'b1};
      vecs[5] = '{44'h13579BDF024, 3'd4, 3'd6, 2,  100, 1'b0};

      do_reset();
      for (int v = 0; v < 6; v++) begin
         run_sample(vecs[v].fv, vecs[v].lbl, vecs[v].pred, vecs[v].hold, vecs[v].pct, got);
         check("table_out_correct", got, vecs[v].exp_correct);
      end

      // reset in the middle of a sample drops the partial words
      for (int i = 0; i < 5; i++) send_word(vecs[1].fv[i*FEAT_BITS +: FEAT_BITS], i, 3'd5, 100);
      do_reset();
      run_sample(vecs[0].fv, vecs[0].lbl, vecs[0].pred, 0, 100, got);
      check("post_rst_correct_cnt", correct_cnt, 1);

      // full run with alternating match / mismatch
      do_reset();
      for (int s = 0; s < TEST_CNT; s++) begin
         rfv = {12'($urandom), $urandom};
         rl  = LBL_W'($urandom_range(0, CLASS_CNT-1));
         run_sample(rfv, rl, (s % 2 == 0) ? rl : junk(rl), $urandom_range(0, 2), 75, got);
      end
      check("final_done", done, 1);
      check("final_correct_cnt", correct_cnt, 500);
      for (int i = 0; i < 10; i++) begin
         in_valid  = 1'b1;
         in_feat   = FEAT_BITS'($urandom);
         out_ready = 1'b1;
         tick();
         check("done_in_ready", in_ready, 0);
         check("done_hold", done, 1);
         check("done_cnt_frozen", correct_cnt, 500);
      end
      in_valid = 1'b0;
      out_ready = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
